// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I decode stage.
// Contents: base opcode values, funct7 qualifiers, the instruction format
// enumeration reported on o_fmt, and the only two legal SYSTEM funct3=0
// encodings (ECALL and EBREAK).
package decode_pkg;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;  // SUB / SRA / SRAI
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_NONE = 3'd6
   } fmt_e;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: combinational instruction + format -> immediate.
// Ports:
//   i_inst  instruction bits [31:7] (the opcode bits never contribute)
//   i_fmt   decoded instruction format
//   o_imm   immediate, sign-extended to DW (zero for R / NONE)
module imm_gen
   import decode_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [31:7]   i_inst,
   input  fmt_e          i_fmt,
   output logic [DW-1:0] o_imm
);

   // Assemble the immediate field for the given format
   always_comb begin
      o_imm = {DW{1'b0}};
      case (i_fmt)
         FMT_I:   o_imm = {{(DW-12){i_inst[31]}}, i_inst[31:20]};
         FMT_S:   o_imm = {{(DW-12){i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
         FMT_B:   o_imm = {{(DW-13){i_inst[31]}}, i_inst[31], i_inst[7],
                           i_inst[30:25], i_inst[11:8], 1'b0};
         FMT_U:   o_imm = {i_inst[31:12], {(DW-20){1'b0}}};
         FMT_J:   o_imm = {{(DW-21){i_inst[31]}}, i_inst[31], i_inst[19:12],
                           i_inst[20], i_inst[30:21], 1'b0};
         default: o_imm = {DW{1'b0}};
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage between fetch and register read / execute.
// Decodes the incoming word combinationally and captures the result in a
// one-entry pipeline register with valid/ready handshakes on both sides.
// Ports:
//   i_clk, i_rst (sync, active-high), i_clk_en (global enable)
//   i_stall  freeze output register, refuse input
//   i_flush  drop held and incoming instruction
//   i_valid / o_ready / i_inst / i_pc        upstream handshake + payload
//   o_valid / i_ready                         downstream handshake
//   o_pc, o_opcode, o_funct3, o_funct7, o_rs1, o_rs2, o_rd, o_imm, o_fmt,
//   o_rs1_used, o_rs2_used, o_rd_we, o_illegal   registered decode results
module decode_stage
   import decode_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter bit EN_RVE   = 1'b0,
   parameter bit EN_M     = 1'b0,
   parameter bit EN_ZICSR = 1'b0
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_clk_en,
   input  logic          i_stall,
   input  logic          i_flush,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [31:0]   i_inst,
   input  logic [AW-1:0] i_pc,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [AW-1:0] o_pc,
   output logic [6:0]    o_opcode,
   output logic [2:0]    o_funct3,
   output logic [6:0]    o_funct7,
   output logic [4:0]    o_rs1,
   output logic [4:0]    o_rs2,
   output logic [4:0]    o_rd,
   output logic [DW-1:0] o_imm,
   output logic [2:0]    o_fmt,
   output logic          o_rs1_used,
   output logic          o_rs2_used,
   output logic          o_rd_we,
   output logic          o_illegal
);

   logic [6:0]    opcode_s;
   logic [2:0]    funct3_s;
   logic [6:0]    funct7_s;
   logic [4:0]    rs1_s;
   logic [4:0]    rs2_s;
   logic [4:0]    rd_s;
   fmt_e          fmt_s;
   logic [DW-1:0] imm_s;
   logic          rs1_use_raw_s;
   logic          rs2_use_raw_s;
   logic          rd_wr_fmt_s;
   logic          rd_we_raw_s;
   logic          enc_bad_s;
   logic          rve_bad_s;
   logic          illegal_s;
   logic          ready_s;
   logic          accept_s;
   logic          xfer_s;

   logic          valid_r;
   logic [AW-1:0] pc_r;
   logic [6:0]    opcode_r;
   logic [2:0]    funct3_r;
   logic [6:0]    funct7_r;
   logic [4:0]    rs1_r;
   logic [4:0]    rs2_r;
   logic [4:0]    rd_r;
   logic [DW-1:0] imm_r;
   fmt_e          fmt_r;
   logic          rs1_used_r;
   logic          rs2_used_r;
   logic          rd_we_r;
   logic          illegal_r;

   assign opcode_s = i_inst[6:0];
   assign funct3_s = i_inst[14:12];
   assign funct7_s = i_inst[31:25];
   assign rs1_s    = i_inst[19:15];
   assign rs2_s    = i_inst[24:20];
   assign rd_s     = i_inst[11:7];

   // Map opcode to instruction format
   always_comb begin
      fmt_s = FMT_NONE;
      case (opcode_s)
         OPC_LUI, OPC_AUIPC:                    fmt_s = FMT_U;
         OPC_JAL:                               fmt_s = FMT_J;
         OPC_JALR, OPC_LOAD, OPC_OP_IMM,
         OPC_SYSTEM, OPC_MISC_MEM:              fmt_s = FMT_I;
         OPC_STORE:                             fmt_s = FMT_S;
         OPC_BRANCH:                            fmt_s = FMT_B;
         OPC_OP:                                fmt_s = FMT_R;
         default:                               fmt_s = FMT_NONE;
      endcase
   end

   // Operand usage implied by the format, before the legality mask
   always_comb begin
      rs1_use_raw_s = 1'b0;
      rs2_use_raw_s = 1'b0;
      rd_wr_fmt_s   = 1'b0;
      case (fmt_s)
         FMT_R: begin
            rs1_use_raw_s = 1'b1;
            rs2_use_raw_s = 1'b1;
            rd_wr_fmt_s   = 1'b1;
         end
         FMT_I: begin
            // CSR immediate forms (funct3[2]=1) carry a uimm in the rs1 slot
            rs1_use_raw_s = !((opcode_s == OPC_SYSTEM) && funct3_s[2]);
            rd_wr_fmt_s   = 1'b1;
         end
         FMT_S, FMT_B: begin
            rs1_use_raw_s = 1'b1;
            rs2_use_raw_s = 1'b1;
         end
         FMT_U, FMT_J: begin
            rd_wr_fmt_s   = 1'b1;
         end
         default: begin
            rs1_use_raw_s = 1'b0;
            rs2_use_raw_s = 1'b0;
            rd_wr_fmt_s   = 1'b0;
         end
      endcase
   end

   assign rd_we_raw_s = rd_wr_fmt_s && (rd_s != 5'd0);

   // Per-opcode reserved / unsupported encoding check
   always_comb begin
      enc_bad_s = 1'b0;
      case (opcode_s)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISC_MEM: enc_bad_s = 1'b0;
         OPC_JALR:   enc_bad_s = (funct3_s != 3'd0);
         OPC_BRANCH: enc_bad_s = (funct3_s == 3'd2) || (funct3_s == 3'd3);
         OPC_LOAD:   enc_bad_s = (funct3_s == 3'd3) || (funct3_s == 3'd6) ||
                                 (funct3_s == 3'd7);
         OPC_STORE:  enc_bad_s = (funct3_s > 3'd2);
         OPC_OP_IMM: begin
            // Shift immediates reuse the upper bits as a funct7 qualifier
            if (funct3_s == 3'd1) begin
               enc_bad_s = (funct7_s != F7_BASE);
            end else if (funct3_s == 3'd5) begin
               enc_bad_s = (funct7_s != F7_BASE) && (funct7_s != F7_ALT);
            end else begin
               enc_bad_s = 1'b0;
            end
         end
         OPC_OP: begin
            enc_bad_s = !((funct7_s == F7_BASE) ||
                          ((funct7_s == F7_ALT) &&
                           ((funct3_s == 3'd0) || (funct3_s == 3'd5))) ||
                          ((funct7_s == F7_MULDIV) && EN_M));
         end
         OPC_SYSTEM: begin
            if (funct3_s != 3'd0) begin
               enc_bad_s = !EN_ZICSR;
            end else begin
               enc_bad_s = (i_inst != INST_ECALL) && (i_inst != INST_EBREAK);
            end
         end
         default:    enc_bad_s = 1'b1;
      endcase
   end

   // RV32E only has x0..x15; any referenced index with bit 4 set is out of range
   assign rve_bad_s = EN_RVE && ((rs1_use_raw_s && rs1_s[4]) ||
                                 (rs2_use_raw_s && rs2_s[4]) ||
                                 (rd_we_raw_s   && rd_s[4]));

   assign illegal_s = (i_inst[1:0] != 2'b11) || enc_bad_s || rve_bad_s;

   imm_gen #(
      .DW (DW)
   ) u_imm_gen (
      .i_inst (i_inst[31:7]),
      .i_fmt  (fmt_s),
      .o_imm  (imm_s)
   );

   // Handshake: a stalled stage neither accepts nor releases its word
   assign ready_s  = !i_stall && (!valid_r || i_ready);
   assign accept_s = i_valid && ready_s && !i_flush;
   assign xfer_s   = valid_r && i_ready && !i_stall;

   // Pipeline register; flush wins over accept and stall
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_r    <= 1'b0;
         pc_r       <= {AW{1'b0}};
         opcode_r   <= 7'd0;
         funct3_r   <= 3'd0;
         funct7_r   <= 7'd0;
         rs1_r      <= 5'd0;
         rs2_r      <= 5'd0;
         rd_r       <= 5'd0;
         imm_r      <= {DW{1'b0}};
         fmt_r      <= FMT_NONE;
         rs1_used_r <= 1'b0;
         rs2_used_r <= 1'b0;
         rd_we_r    <= 1'b0;
         illegal_r  <= 1'b0;
      end else if (i_clk_en) begin
         if (i_flush) begin
            valid_r <= 1'b0;
         end else if (accept_s) begin
            valid_r    <= 1'b1;
            pc_r       <= i_pc;
            opcode_r   <= opcode_s;
            funct3_r   <= funct3_s;
            funct7_r   <= funct7_s;
            rs1_r      <= rs1_s;
            rs2_r      <= rs2_s;
            rd_r       <= rd_s;
            imm_r      <= imm_s;
            fmt_r      <= fmt_s;
            rs1_used_r <= rs1_use_raw_s && !illegal_s;
            rs2_used_r <= rs2_use_raw_s && !illegal_s;
            rd_we_r    <= rd_we_raw_s && !illegal_s;
            illegal_r  <= illegal_s;
         end else if (xfer_s) begin
            valid_r <= 1'b0;
         end else begin
            valid_r <= valid_r;
         end
      end else begin
         valid_r <= valid_r;
      end
   end

   assign o_ready    = ready_s;
   assign o_valid    = valid_r;
   assign o_pc       = pc_r;
   assign o_opcode   = opcode_r;
   assign o_funct3   = funct3_r;
   assign o_funct7   = funct7_r;
   assign o_rs1      = rs1_r;
   assign o_rs2      = rs2_r;
   assign o_rd       = rd_r;
   assign o_imm      = imm_r;
   assign o_fmt      = fmt_r;
   assign o_rs1_used = rs1_used_r;
   assign o_rs2_used = rs2_used_r;
   assign o_rd_we    = rd_we_r;
   assign o_illegal  = illegal_r;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage. Two instances share all inputs:
// dut (all extensions off) and dut_x (EN_RVE, EN_M, EN_ZICSR all on).
module tb_decode_stage;
   import decode_pkg::*;

   logic        i_clk;
   logic        i_rst;
   logic        i_clk_en;
   logic        i_stall;
   logic        i_flush;
   logic        i_valid;
   logic        i_ready;
   logic [31:0] i_inst;
   logic [31:0] i_pc;

   logic        o_ready, o_valid, o_rs1_used, o_rs2_used, o_rd_we, o_illegal;
   logic [31:0] o_pc, o_imm;
   logic [6:0]  o_opcode, o_funct7;
   logic [2:0]  o_funct3, o_fmt;
   logic [4:0]  o_rs1, o_rs2, o_rd;

   logic        x_ready, x_valid, x_rs1_used, x_rs2_used, x_rd_we, x_illegal;
   logic [31:0] x_pc, x_imm;
   logic [6:0]  x_opcode, x_funct7;
   logic [2:0]  x_funct3, x_fmt;
   logic [4:0]  x_rs1, x_rs2, x_rd;

   int checks = 0;
   int errors = 0;

   decode_stage #(.AW(32), .DW(32), .EN_RVE(1'b0), .EN_M(1'b0), .EN_ZICSR(1'b0)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en), .i_stall(i_stall),
      .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready), .i_inst(i_inst),
      .i_pc(i_pc), .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc),
      .o_opcode(o_opcode), .o_funct3(o_funct3), .o_funct7(o_funct7),
      .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_imm(o_imm), .o_fmt(o_fmt),
      .o_rs1_used(o_rs1_used), .o_rs2_used(o_rs2_used), .o_rd_we(o_rd_we),
      .o_illegal(o_illegal)
   );

   decode_stage #(.AW(32), .DW(32), .EN_RVE(1'b1), .EN_M(1'b1), .EN_ZICSR(1'b1)) dut_x (
      .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en), .i_stall(i_stall),
      .i_flush(i_flush), .i_valid(i_valid), .o_ready(x_ready), .i_inst(i_inst),
      .i_pc(i_pc), .o_valid(x_valid), .i_ready(i_ready), .o_pc(x_pc),
      .o_opcode(x_opcode), .o_funct3(x_funct3), .o_funct7(x_funct7),
      .o_rs1(x_rs1), .o_rs2(x_rs2), .o_rd(x_rd), .o_imm(x_imm), .o_fmt(x_fmt),
      .o_rs1_used(x_rs1_used), .o_rs2_used(x_rs2_used), .o_rd_we(x_rd_we),
      .o_illegal(x_illegal)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Present one word for a single cycle; returns #1 after the capturing edge
   task automatic send(input logic [31:0] inst, input logic [31:0] pc);
      i_valid = 1'b1;
      i_inst  = inst;
      i_pc    = pc;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_clk_en = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
      i_valid = 1'b0; i_ready = 1'b1; i_inst = 32'd0; i_pc = 32'd0;
      repeat (2) @(posedge i_clk);
      #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", o_valid); end
      checks++; if (o_imm !== 32'd0) begin errors++; $display("FAIL reset_imm got %h exp 0", o_imm); end
      checks++; if (o_fmt !== FMT_NONE) begin errors++; $display("FAIL reset_fmt got %0d exp %0d", o_fmt, FMT_NONE); end
      checks++; if (o_rd !== 5'd0 || o_pc !== 32'd0 || o_rd_we !== 1'b0) begin errors++; $display("FAIL reset_fields rd %0d pc %h we %0b exp 0", o_rd, o_pc, o_rd_we); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", o_ready); end
      i_rst = 1'b0;
   endtask

   task automatic test_addi();
      send(32'hFFF0_0093, 32'h0000_0100);
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0b exp 1", o_valid); end
      checks++; if (o_rd !== 5'd1 || o_rs1 !== 5'd0) begin errors++; $display("FAIL addi_regs rd %0d rs1 %0d exp 1 0", o_rd, o_rs1); end
      checks++; if (o_imm !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_imm got %h exp ffffffff", o_imm); end
      checks++; if (o_fmt !== FMT_I) begin errors++; $display("FAIL addi_fmt got %0d exp %0d", o_fmt, FMT_I); end
      checks++; if (o_rd_we !== 1'b1 || o_illegal !== 1'b0) begin errors++; $display("FAIL addi_we_ill we %0b ill %0b exp 1 0", o_rd_we, o_illegal); end
      checks++; if (o_rs1_used !== 1'b1 || o_rs2_used !== 1'b0) begin errors++; $display("FAIL addi_used %0b%0b exp 10", o_rs1_used, o_rs2_used); end
      checks++; if (o_pc !== 32'h0000_0100) begin errors++; $display("FAIL addi_pc got %h exp 100", o_pc); end
   endtask

   task automatic test_formats();
      send(32'h0020_A423, 32'h0000_0104);   // sw x2,8(x1)
      checks++; if (o_imm !== 32'd8 || o_fmt !== FMT_S) begin errors++; $display("FAIL sw_imm_fmt imm %h fmt %0d exp 8 %0d", o_imm, o_fmt, FMT_S); end
      checks++; if (o_rs1 !== 5'd1 || o_rs2 !== 5'd2 || o_rd_we !== 1'b0) begin errors++; $display("FAIL sw_regs rs1 %0d rs2 %0d we %0b exp 1 2 0", o_rs1, o_rs2, o_rd_we); end
      checks++; if (o_rs2_used !== 1'b1 || o_funct3 !== 3'd2) begin errors++; $display("FAIL sw_used_f3 %0b %0d exp 1 2", o_rs2_used, o_funct3); end
      send(32'hFE00_0EE3, 32'h0000_0108);   // beq x0,x0,-4
      checks++; if (o_imm !== 32'hFFFF_FFFC || o_fmt !== FMT_B) begin errors++; $display("FAIL beq imm %h fmt %0d exp fffffffc %0d", o_imm, o_fmt, FMT_B); end
      send(32'h1234_52B7, 32'h0000_010C);   // lui x5,0x12345
      checks++; if (o_imm !== 32'h1234_5000 || o_fmt !== FMT_U) begin errors++; $display("FAIL lui imm %h fmt %0d exp 12345000 %0d", o_imm, o_fmt, FMT_U); end
      checks++; if (o_rd !== 5'd5 || o_rd_we !== 1'b1 || o_rs1_used !== 1'b0) begin errors++; $display("FAIL lui_regs rd %0d we %0b r1u %0b exp 5 1 0", o_rd, o_rd_we, o_rs1_used); end
      send(32'h0010_00EF, 32'h0000_0110);   // jal x1,+2048
      checks++; if (o_imm !== 32'h0000_0800 || o_fmt !== FMT_J) begin errors++; $display("FAIL jal imm %h fmt %0d exp 800 %0d", o_imm, o_fmt, FMT_J); end
   endtask

   task automatic test_illegal();
      send(32'h0000_0000, 32'h0000_0200);
      checks++; if (o_illegal !== 1'b1 || o_rd_we !== 1'b0 || o_rs1_used !== 1'b0) begin errors++; $display("FAIL zero_word ill %0b we %0b r1u %0b exp 1 0 0", o_illegal, o_rd_we, o_rs1_used); end
      send(32'h0231_00B3, 32'h0000_0204);   // mul x1,x2,x3
      checks++; if (o_illegal !== 1'b1 || o_rd_we !== 1'b0) begin errors++; $display("FAIL mul_nom ill %0b we %0b exp 1 0", o_illegal, o_rd_we); end
      checks++; if (x_illegal !== 1'b0 || x_rd_we !== 1'b1) begin errors++; $display("FAIL mul_m ill %0b we %0b exp 0 1", x_illegal, x_rd_we); end
      send(32'h0000_0813, 32'h0000_0208);   // addi x16,x0,0
      checks++; if (o_illegal !== 1'b0 || o_rd_we !== 1'b1 || o_rd !== 5'd16) begin errors++; $display("FAIL x16_rvi ill %0b we %0b rd %0d exp 0 1 16", o_illegal, o_rd_we, o_rd); end
      checks++; if (x_illegal !== 1'b1 || x_rd_we !== 1'b0) begin errors++; $display("FAIL x16_rve ill %0b we %0b exp 1 0", x_illegal, x_rd_we); end
      send(32'h3400_1073, 32'h0000_020C);   // csrrw x0,mscratch,x0
      checks++; if (o_illegal !== 1'b1 || x_illegal !== 1'b0) begin errors++; $display("FAIL csr ill %0b/%0b exp 1/0", o_illegal, x_illegal); end
      send(32'h0000_0073, 32'h0000_0210);   // ecall
      checks++; if (o_illegal !== 1'b0 || o_fmt !== FMT_I) begin errors++; $display("FAIL ecall ill %0b fmt %0d exp 0 %0d", o_illegal, o_fmt, FMT_I); end
      send(32'h0010_0074, 32'h0000_0214);   // bad low bits
      checks++; if (o_illegal !== 1'b1) begin errors++; $display("FAIL low_bits ill %0b exp 1", o_illegal); end
      send(32'h4010_5093, 32'h0000_0218);   // srai x1,x0,1
      checks++; if (o_illegal !== 1'b0) begin errors++; $display("FAIL srai ill %0b exp 0", o_illegal); end
      send(32'h4010_1093, 32'h0000_021C);   // slli with funct7=0100000
      checks++; if (o_illegal !== 1'b1) begin errors++; $display("FAIL slli_f7 ill %0b exp 1", o_illegal); end
      send(32'h0000_1067, 32'h0000_0220);   // jalr funct3=1
      checks++; if (o_illegal !== 1'b1) begin errors++; $display("FAIL jalr_f3 ill %0b exp 1", o_illegal); end
      send(32'h0000_3003, 32'h0000_0224);   // load funct3=3
      checks++; if (o_illegal !== 1'b1) begin errors++; $display("FAIL load_f3 ill %0b exp 1", o_illegal); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w;
      i_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         w = {12'(k), 5'd0, 3'd0, 5'(k + 1), 7'h13};   // addi x(k+1),x0,k
         i_valid = 1'b1; i_inst = w; i_pc = 32'h0000_0300 + 32'(4 * k);
         @(posedge i_clk); #1;
         checks++;
         if (o_valid !== 1'b1 || o_rd !== 5'(k + 1) || o_imm !== 32'(k) ||
             o_pc !== 32'h0000_0300 + 32'(4 * k)) begin
            errors++;
            $display("FAIL b2b_%0d valid %0b rd %0d imm %h pc %h exp 1 %0d %h %h", k,
                     o_valid, o_rd, o_imm, o_pc, k + 1, k, 32'h300 + 32'(4 * k));
         end
      end
      // Stall holds word 4 and refuses new input even though i_ready=1
      i_stall = 1'b1; i_inst = 32'h0000_0493; i_pc = 32'h0000_0400;
      #1;
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %0b exp 0", o_ready); end
      for (int k = 0; k < 3; k++) begin
         @(posedge i_clk); #1;
         checks++;
         if (o_valid !== 1'b1 || o_rd !== 5'd4 || o_pc !== 32'h0000_030C || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold_%0d valid %0b rd %0d pc %h rdy %0b exp 1 4 30c 0", k, o_valid, o_rd, o_pc, o_ready);
         end
      end
      i_stall = 1'b0; i_valid = 1'b0;
      @(posedge i_clk); #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stall_release valid %0b exp 0", o_valid); end
      // Downstream not ready: full stage refuses input
      i_ready = 1'b0;
      send(32'h0000_0393, 32'h0000_0500);   // addi x7
      checks++; if (o_valid !== 1'b1 || o_ready !== 1'b0) begin errors++; $display("FAIL full_ready valid %0b rdy %0b exp 1 0", o_valid, o_ready); end
      send(32'h0000_0413, 32'h0000_0504);   // addi x8, must not load
      checks++; if (o_rd !== 5'd7 || o_pc !== 32'h0000_0500) begin errors++; $display("FAIL full_hold rd %0d pc %h exp 7 500", o_rd, o_pc); end
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL full_drain valid %0b exp 0", o_valid); end
   endtask

   task automatic test_flush();
      i_ready = 1'b0;
      send(32'h0000_0513, 32'h0000_0600);   // addi x10, held
      i_ready = 1'b1; i_flush = 1'b1; i_valid = 1'b1;
      i_inst = 32'h0000_0593; i_pc = 32'h0000_0604;   // addi x11, dropped
      @(posedge i_clk); #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_kill valid %0b exp 0", o_valid); end
      i_flush = 1'b0; i_valid = 1'b0;
      @(posedge i_clk); #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_drop valid %0b exp 0", o_valid); end
   endtask

   task automatic test_reset_mid();
      i_ready = 1'b0;
      send(32'h0000_0613, 32'h0000_0700);   // addi x12, held
      i_rst = 1'b1; i_clk_en = 1'b0;
      @(posedge i_clk); #1;
      checks++; if (o_valid !== 1'b0 || o_rd !== 5'd0 || o_fmt !== FMT_NONE) begin errors++; $display("FAIL reset_mid valid %0b rd %0d fmt %0d exp 0 0 %0d", o_valid, o_rd, o_fmt, FMT_NONE); end
      i_rst = 1'b0; i_clk_en = 1'b1; i_ready = 1'b1;
   endtask

   task automatic test_clk_en();
      i_ready = 1'b0;
      send(32'h0000_0693, 32'h0000_0800);   // addi x13, held
      i_clk_en = 1'b0; i_ready = 1'b1; i_valid = 1'b1;
      i_inst = 32'h0000_0713; i_pc = 32'h0000_0804;   // addi x14
      #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL clken_ready got %0b exp 1", o_ready); end
      repeat (2) @(posedge i_clk);
      #1;
      checks++; if (o_valid !== 1'b1 || o_rd !== 5'd13 || o_pc !== 32'h0000_0800) begin errors++; $display("FAIL clken_hold valid %0b rd %0d pc %h exp 1 13 800", o_valid, o_rd, o_pc); end
      i_valid = 1'b0; i_clk_en = 1'b1;
      @(posedge i_clk); #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL clken_resume valid %0b exp 0", o_valid); end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_formats();
      test_illegal();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_clk_en();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
